delay_ctrl: RTL and testbench

Pointer and fill sequencer for a RAM-backed ring-buffer delay line in the DVI pixel path. The delay is selectable at runtime.
- Drives write/read addresses and write enable of an external single-port-write / single-port-read RAM. The RAM is read-first, with 1-cycle registered read.
- Accepts delay reconfiguration through a valid/ready handshake.
- Qualifies RAM read data with a valid flag, so the output is never marked valid until the buffer holds the requested history.

---
 rtl/delay_ctrl_pkg.sv | 22 ++
 rtl/delay_ctrl.sv | 97 +++++++++
 tb/tb_delay_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the ring-buffer delay sequencer.
package delay_ctrl_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } delay_ctrl_state_e;

   // A zero delay makes no sense for a ring buffer, and anything longer than
   // the buffer cannot be honoured, so requests are pinned into 1..depth.
   function automatic int unsigned clamp_delay(input int unsigned req,
                                               input int unsigned depth);
      if (req == 0) begin
         return 1;
      end else if (req > depth) begin
         return depth;
      end else begin
         return req;
      end
   endfunction

endpackage

// File: rtl/delay_ctrl.sv
// Pointer and fill sequencer for a RAM-backed ring-buffer delay line.
// The write pointer free-runs on every sample strobe; the read pointer trails
// it by the configured delay. A fill counter keeps the output qualified low
// until the buffer really holds that much history.
module delay_ctrl
   import delay_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH         = 1024,
   parameter int unsigned DEFAULT_DELAY = 16,
   localparam int W_PTR = $clog2(DEPTH),
   localparam int W_DLY = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             cfg_valid_i,
   input  logic [W_DLY-1:0] cfg_delay_i,
   output logic             cfg_ready_o,
   output logic             mem_we_o,
   output logic [W_PTR-1:0] mem_waddr_o,
   output logic [W_PTR-1:0] mem_raddr_o,
   output logic             out_valid_o,
   output logic             busy_o,
   output logic [W_DLY-1:0] cur_delay_o
);

   localparam int W_EXT = W_PTR + 1;

   logic [W_PTR-1:0]  wptr;
   logic [W_DLY-1:0]  delay;
   logic [W_DLY-1:0]  fill_cnt;
   logic [W_DLY-1:0]  fill_next;
   logic [W_EXT-1:0]  rdiff;
   logic              cfg_accept;
   logic              out_valid;
   delay_ctrl_state_e state;

   assign cfg_ready_o = ~rst_i;
   assign cfg_accept  = cfg_valid_i & cfg_ready_o;
   assign fill_next   = fill_cnt + W_DLY'(1);

   assign mem_we_o    = en_i;
   assign mem_waddr_o = wptr;
   assign mem_raddr_o = rdiff[W_PTR-1:0];
   assign out_valid_o = out_valid;
   assign busy_o      = (state == ST_FILL);
   assign cur_delay_o = delay;

   // Read address is wptr - delay modulo DEPTH; one extra bit catches the
   // borrow so non-power-of-two depths wrap correctly. delay == DEPTH lands
   // on the write address, where the read-first RAM yields the oldest entry.
   always_comb begin
      rdiff = {1'b0, wptr} - W_EXT'(delay);
      if (rdiff[W_PTR]) begin
         rdiff = rdiff + W_EXT'(DEPTH);
      end
   end

   // Write pointer advances on every strobe regardless of fill state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr <= '0;
      end else if (en_i) begin
         wptr <= (wptr == W_PTR'(DEPTH - 1)) ? '0 : wptr + W_PTR'(1);
      end
   end

   // Output qualifier lines up with the registered RAM read data; a
   // coincident reconfiguration does not retract the strobe already in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= en_i && (state == ST_RUN);
      end
   end

   // Fill sequencing and delay reconfiguration; an accepted request restarts
   // the fill and the strobe sharing its cycle is not counted toward it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         delay    <= W_DLY'(DEFAULT_DELAY);
         fill_cnt <= '0;
         state    <= ST_FILL;
      end else if (cfg_accept) begin
         delay    <= W_DLY'(clamp_delay(32'(cfg_delay_i), DEPTH));
         fill_cnt <= '0;
         state    <= ST_FILL;
      end else if ((state == ST_FILL) && en_i) begin
         fill_cnt <= fill_next;
         if (fill_next == delay) begin
            state <= ST_RUN;
         end
      end
   end

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl with a small read-first RAM in the loop.
// Each strobe writes a running sample index so the read data identifies
// exactly which earlier sample came back.
module tb_delay_ctrl;

   localparam int DEPTH = 16;
   localparam int DDLY  = 4;
   localparam int W_PTR = 4;
   localparam int W_DLY = 5;

   logic             clk;
   logic             rst_i;
   logic             en_i;
   logic             cfg_valid_i;
   logic [W_DLY-1:0] cfg_delay_i;
   logic             cfg_ready_o;
   logic             mem_we_o;
   logic [W_PTR-1:0] mem_waddr_o;
   logic [W_PTR-1:0] mem_raddr_o;
   logic             out_valid_o;
   logic             busy_o;
   logic [W_DLY-1:0] cur_delay_o;

   logic [7:0] mem [DEPTH];
   logic [7:0] wdata;
   logic [7:0] rdata;

   int total;
   int bad;
   int gidx;
   int base;

   delay_ctrl #(
      .DEPTH         (DEPTH),
      .DEFAULT_DELAY (DDLY)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_delay_i (cfg_delay_i),
      .cfg_ready_o (cfg_ready_o),
      .mem_we_o    (mem_we_o),
      .mem_waddr_o (mem_waddr_o),
      .mem_raddr_o (mem_raddr_o),
      .out_valid_o (out_valid_o),
      .busy_o      (busy_o),
      .cur_delay_o (cur_delay_o)
   );

   // Free-running pixel clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (mem_we_o) begin
         mem[mem_waddr_o] <= wdata;
      end
      rdata <= mem[mem_raddr_o];
   end

   task automatic checkOutput(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic cv,
                                input logic [W_DLY-1:0] cd);
      en_i        = en;
      cfg_valid_i = cv;
      cfg_delay_i = cd;
      wdata       = gidx[7:0];
      tick();
      if (en) begin
         gidx++;
      end
      en_i        = 1'b0;
      cfg_valid_i = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      gidx        = 0;
      rst_i       = 1'b1;
      en_i        = 1'b0;
      cfg_valid_i = 1'b0;
      cfg_delay_i = '0;
      wdata       = '0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_ready", cfg_ready_o, 0);
      checkOutput("rst_busy", busy_o, 1);
      checkOutput("rst_valid", out_valid_o, 0);
      checkOutput("rst_delay", cur_delay_o, DDLY);
      checkOutput("rst_waddr", mem_waddr_o, 0);
      checkOutput("rst_raddr", mem_raddr_o, 12);
      rst_i = 1'b0;
      #1;
      checkOutput("ready_run", cfg_ready_o, 1);

      // Continuous streaming at the default delay
      $display("[TB] continuous stream, delay 4");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         checkOutput("cont_valid", out_valid_o, (i >= 4) ? 1 : 0);
         checkOutput("cont_busy", busy_o, (i < 3) ? 1 : 0);
         if (i >= 4) checkOutput("cont_data", rdata, i - 4);
      end

      // Gapped strobes, one per three cycles
      $display("[TB] gapped stream");
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b1, 1'b0, '0);
         checkOutput("gap_valid", out_valid_o, 1);
         checkOutput("gap_data", rdata, 8 + j);
         applyStimulus(1'b0, 1'b0, '0);
         checkOutput("gap_idle1", out_valid_o, 0);
         applyStimulus(1'b0, 1'b0, '0);
         checkOutput("gap_idle2", out_valid_o, 0);
      end

      // Reconfigure 4 -> 8 in RUN while streaming
      $display("[TB] reconfig to 8");
      applyStimulus(1'b1, 1'b1, 5'd8);
      checkOutput("rc_valid", out_valid_o, 1);
      checkOutput("rc_data", rdata, 12);
      checkOutput("rc_busy", busy_o, 1);
      checkOutput("rc_delay", cur_delay_o, 8);
      for (int j = 0; j < 8; j++) begin
         applyStimulus(1'b1, 1'b0, '0);
         checkOutput("rc_fill_valid", out_valid_o, 0);
      end
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("rc_first_valid", out_valid_o, 1);
      checkOutput("rc_first_data", rdata, 17);
      checkOutput("rc_run_busy", busy_o, 0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("rc_next_data", rdata, 18);

      // Full-depth delay across pointer wraps
      $display("[TB] delay 16 wrap");
      applyStimulus(1'b0, 1'b1, 5'd16);
      checkOutput("wr_delay", cur_delay_o, 16);
      checkOutput("wr_busy", busy_o, 1);
      base = gidx;
      for (int k = 0; k < 40; k++) begin
         checkOutput("wr_raddr", mem_raddr_o, int'(mem_waddr_o));
         applyStimulus(1'b1, 1'b0, '0);
         checkOutput("wr_valid", out_valid_o, (k >= 16) ? 1 : 0);
         if (k >= 16) checkOutput("wr_data", rdata, (base + k - 16) & 255);
      end

      // Clamping at both ends
      $display("[TB] clamping");
      applyStimulus(1'b0, 1'b1, 5'd0);
      checkOutput("clamp_lo", cur_delay_o, 1);
      checkOutput("clamp_lo_busy", busy_o, 1);
      base = gidx;
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("d1_fill_valid", out_valid_o, 0);
      checkOutput("d1_busy", busy_o, 0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("d1_valid", out_valid_o, 1);
      checkOutput("d1_data", rdata, base & 255);
      applyStimulus(1'b0, 1'b1, 5'd20);
      checkOutput("clamp_hi", cur_delay_o, 16);

      // Accept coincident with a strobe while in FILL
      $display("[TB] coincident accept");
      applyStimulus(1'b1, 1'b1, 5'd2);
      checkOutput("co_valid", out_valid_o, 0);
      checkOutput("co_delay", cur_delay_o, 2);
      base = gidx;
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("co_busy1", busy_o, 1);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("co_busy2", busy_o, 0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("co_run_valid", out_valid_o, 1);
      checkOutput("co_run_data", rdata, base & 255);

      // Reset in the middle of a fill, with cfg and strobe also asserted
      $display("[TB] reset mid-fill");
      applyStimulus(1'b0, 1'b1, 5'd8);
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("mf_busy", busy_o, 1);
      rst_i       = 1'b1;
      en_i        = 1'b1;
      cfg_valid_i = 1'b1;
      cfg_delay_i = 5'd3;
      #1;
      checkOutput("mf_ready_rst", cfg_ready_o, 0);
      checkOutput("mf_we", mem_we_o, 1);
      tick();
      rst_i       = 1'b0;
      en_i        = 1'b0;
      cfg_valid_i = 1'b0;
      #1;
      checkOutput("mf_waddr", mem_waddr_o, 0);
      checkOutput("mf_delay", cur_delay_o, DDLY);
      checkOutput("mf_busy_rst", busy_o, 1);
      checkOutput("mf_valid", out_valid_o, 0);
      checkOutput("mf_raddr", mem_raddr_o, 12);
      base = gidx;
      for (int j = 0; j < 6; j++) begin
         applyStimulus(1'b1, 1'b0, '0);
         checkOutput("pr_valid", out_valid_o, (j >= 4) ? 1 : 0);
         if (j >= 4) checkOutput("pr_data", rdata, (base + j - 4) & 255);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
